// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the downstream sequence detectors: accepts
// WIDTH-bit words on a valid/ready handshake and emits one bit per clock.
module serial_word_feeder #(
  parameter int WIDTH      = 6,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             flush,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [WIDTH-1:0] hold, hold_next;
  logic             hold_full, hold_full_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             accept;
  logic             at_last;
  logic [WIDTH-1:0] sreg_shifted;

  assign load_ready   = ~hold_full & ~reset & ~flush;
  assign accept       = load_valid & load_ready;
  assign at_last      = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign busy         = (state == SHIFT) | hold_full;
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  // Outputs are decoded from registered state only, so the detector's din
  // never sees a combinational path from the handshake inputs.
  always_comb begin
    dout       = IDLE_LEVEL;
    dout_valid = 1'b0;
    last       = 1'b0;
    if (state == SHIFT) begin
      dout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
      dout_valid = 1'b1;
      last       = at_last;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case below can leave one unassigned and infer a latch.
    state_next     = state;
    sreg_next      = sreg;
    hold_next      = hold;
    hold_full_next = hold_full;
    cnt_next       = cnt;

    if (flush) begin
      state_next     = IDLE;
      sreg_next      = '0;
      hold_full_next = 1'b0;
      cnt_next       = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sreg_next  = data_in;
            cnt_next   = '0;
            state_next = SHIFT;
          end
        end
        SHIFT: begin
          if (at_last) begin
            // Reloading at the word boundary keeps the bit stream gap-free.
            cnt_next = '0;
            if (hold_full) begin
              sreg_next      = hold;
              hold_full_next = 1'b0;
            end else if (accept) begin
              sreg_next = data_in;
            end else begin
              state_next = IDLE;
            end
          end else begin
            sreg_next = sreg_shifted;
            cnt_next  = cnt + CW'(1);
            if (accept) begin
              hold_next      = data_in;
              hold_full_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      hold      <= hold_next;
      hold_full <= hold_full_next;
      cnt       <= cnt_next;
    end
  end

endmodule
